// File: rtl/wb_gpio_pkg.sv
// Shared constants and helpers for the Wishbone GPIO/interrupt controller.
// Register offsets are word indices (wbs_adr_i[7:2]).
package wb_gpio_pkg;

  localparam int unsigned MAX_IO   = 64;
  localparam int unsigned MAX_IRQ  = 3;
  localparam logic [7:0]  ID_MAGIC = 8'h47;

  localparam logic [5:0] REG_OUT_LO  = 6'h00;
  localparam logic [5:0] REG_OUT_HI  = 6'h01;
  localparam logic [5:0] REG_OEB_LO  = 6'h02;
  localparam logic [5:0] REG_OEB_HI  = 6'h03;
  localparam logic [5:0] REG_IN_LO   = 6'h04;
  localparam logic [5:0] REG_IN_HI   = 6'h05;
  localparam logic [5:0] REG_IE_LO   = 6'h06;
  localparam logic [5:0] REG_IE_HI   = 6'h07;
  localparam logic [5:0] REG_POL_LO  = 6'h08;
  localparam logic [5:0] REG_POL_HI  = 6'h09;
  localparam logic [5:0] REG_STAT_LO = 6'h0A;
  localparam logic [5:0] REG_STAT_HI = 6'h0B;
  localparam logic [5:0] REG_ID      = 6'h0C;

  // Pins feeding a given interrupt line: every pin i < n_io with i % n_irq == line.
  function automatic logic [MAX_IO-1:0] irq_line_mask(input int unsigned line,
                                                      input int unsigned n_io,
                                                      input int unsigned n_irq);
    logic [MAX_IO-1:0] m;
    m = '0;
    if (n_irq != 0 && n_irq <= MAX_IRQ) begin
      for (int unsigned i = 0; i < MAX_IO; i++) begin
        if (i < n_io && (i % n_irq) == line) m[i] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/wb_gpio_sync.sv
// N-bit pad input synchroniser followed by a registered filtered value.
// Define WB_GPIO_DEBOUNCE_EN to insert a per-pin DEB_CYCLES debounce counter.
module wb_gpio_sync #(
  parameter int unsigned N          = 38,
  parameter int unsigned STAGES     = 2,
  parameter int unsigned DEB_CYCLES = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o
);

  logic [STAGES-1:0][N-1:0] sync_q;
  logic [N-1:0]             raw;
  logic [N-1:0]             filt_q, filt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int unsigned s = 1; s < STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign raw = sync_q[STAGES-1];

`ifdef WB_GPIO_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);

  logic [N-1:0][CNT_W-1:0] cnt_q, cnt_d;

  // Filtered bit flips one cycle after DEB_CYCLES consecutive mismatches.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    for (int unsigned i = 0; i < N; i++) begin
      if (raw[i] != filt_q[i]) begin
        if (cnt_q[i] == CNT_W'(DEB_CYCLES)) begin
          filt_d[i] = raw[i];
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  logic unused_deb;
  assign unused_deb = (DEB_CYCLES != 0);

  always_comb filt_d = raw;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) filt_q <= '0;
    else         filt_q <= filt_d;
  end

  assign q_o = filt_q;

endmodule

// File: rtl/wb_gpio_irq.sv
// Wishbone-slave GPIO block: per-pin OUT/OEB/IN, edge-triggered W1C status, user_irq.
// Optional input debounce via WB_GPIO_DEBOUNCE_EN (see wb_gpio_sync).
module wb_gpio_irq
  import wb_gpio_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h3000_0000,
  parameter int unsigned N_IO        = 38,
  parameter int unsigned N_IRQ       = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CYCLES  = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  input  logic [N_IO-1:0]  io_in,
  output logic [N_IO-1:0]  io_out,
  output logic [N_IO-1:0]  io_oeb,
  output logic [N_IRQ-1:0] user_irq
);

  localparam logic [63:0] PIN_MASK = (N_IO >= MAX_IO) ? '1 : ((64'd1 << N_IO) - 64'd1);
  localparam logic [31:0] ID_VAL   = {ID_MAGIC, 8'(N_IRQ), 8'(N_IO), 8'(SYNC_STAGES)};

  logic [63:0] out_q, out_d, oeb_q, oeb_d, ie_q, ie_d, pol_q, pol_d;
  logic [63:0] stat_q, stat_d, prev_q, in_w, w1c, edge_hit;
  logic [N_IO-1:0]  in_sync;
  logic [N_IRQ-1:0] irq_q, irq_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d, rdata, bmask;
  logic [5:0]  idx;
  logic        hit, req, wr_en;
  logic        unused_adr;

  wb_gpio_sync #(
    .N          (N_IO),
    .STAGES     (SYNC_STAGES),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_sync (
    .clk_i  (wb_clk_i),
    .rst_ni (wb_rst_ni),
    .d_i    (io_in),
    .q_o    (in_sync)
  );

  assign in_w       = 64'(in_sync);
  assign unused_adr = ^wbs_adr_i[1:0];
  assign idx        = wbs_adr_i[7:2];
  assign hit        = (wbs_adr_i[31:8] == ADDR_BASE[31:8]);
  // Gating on ack_q forces one idle cycle between acks of a held strobe.
  assign req        = wbs_cyc_i & wbs_stb_i & hit & ~ack_q;
  assign wr_en      = req & wbs_we_i;
  assign bmask      = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign edge_hit   = (pol_q & in_w & ~prev_q) | (~pol_q & ~in_w & prev_q);

  function automatic logic [63:0] wr_merge(input logic [63:0] cur, input logic hi,
                                           input logic [31:0] dat, input logic [31:0] m);
    logic [63:0] r;
    r = cur;
    if (hi) r[63:32] = (cur[63:32] & ~m) | (dat & m);
    else    r[31:0]  = (cur[31:0]  & ~m) | (dat & m);
    return r & PIN_MASK;
  endfunction

  always_comb begin
    out_d = out_q;
    oeb_d = oeb_q;
    ie_d  = ie_q;
    pol_d = pol_q;
    w1c   = '0;
    if (wr_en) begin
      case (idx)
        REG_OUT_LO, REG_OUT_HI:   out_d = wr_merge(out_q, idx[0], wbs_dat_i, bmask);
        REG_OEB_LO, REG_OEB_HI:   oeb_d = wr_merge(oeb_q, idx[0], wbs_dat_i, bmask);
        REG_IE_LO,  REG_IE_HI:    ie_d  = wr_merge(ie_q,  idx[0], wbs_dat_i, bmask);
        REG_POL_LO, REG_POL_HI:   pol_d = wr_merge(pol_q, idx[0], wbs_dat_i, bmask);
        REG_STAT_LO:              w1c[31:0]  = wbs_dat_i & bmask;
        REG_STAT_HI:              w1c[63:32] = wbs_dat_i & bmask;
        default: ;
      endcase
    end
    // A new edge in the same cycle as its W1C keeps the bit set.
    stat_d = ((stat_q & ~w1c) | edge_hit) & PIN_MASK;
  end

  always_comb begin
    rdata = '0;
    case (idx)
      REG_OUT_LO:  rdata = out_q[31:0];
      REG_OUT_HI:  rdata = out_q[63:32];
      REG_OEB_LO:  rdata = oeb_q[31:0];
      REG_OEB_HI:  rdata = oeb_q[63:32];
      REG_IN_LO:   rdata = in_w[31:0];
      REG_IN_HI:   rdata = in_w[63:32];
      REG_IE_LO:   rdata = ie_q[31:0];
      REG_IE_HI:   rdata = ie_q[63:32];
      REG_POL_LO:  rdata = pol_q[31:0];
      REG_POL_HI:  rdata = pol_q[63:32];
      REG_STAT_LO: rdata = stat_q[31:0];
      REG_STAT_HI: rdata = stat_q[63:32];
      REG_ID:      rdata = ID_VAL;
      default:     rdata = '0;
    endcase
    ack_d = req;
    dat_d = req ? rdata : '0;
  end

  always_comb begin
    irq_d = '0;
    for (int unsigned k = 0; k < N_IRQ; k++) begin
      irq_d[k] = |(stat_q & ie_q & irq_line_mask(k, N_IO, N_IRQ));
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      out_q  <= '0;
      oeb_q  <= PIN_MASK;
      ie_q   <= '0;
      pol_q  <= '0;
      stat_q <= '0;
      prev_q <= '0;
      irq_q  <= '0;
      ack_q  <= 1'b0;
      dat_q  <= '0;
    end else begin
      out_q  <= out_d;
      oeb_q  <= oeb_d;
      ie_q   <= ie_d;
      pol_q  <= pol_d;
      stat_q <= stat_d;
      prev_q <= in_w;
      irq_q  <= irq_d;
      ack_q  <= ack_d;
      dat_q  <= dat_d;
    end
  end

  assign io_out    = out_q[N_IO-1:0];
  assign io_oeb    = oeb_q[N_IO-1:0];
  assign user_irq  = irq_q;
  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

endmodule

// File: tb/tb_wb_gpio_irq.sv
// Directed self-checking bench for wb_gpio_irq (N_IO=38, N_IRQ=3, SYNC_STAGES=2).
module tb_wb_gpio_irq;

  localparam logic [31:0] BASE = 32'h3000_0000;
`ifdef WB_GPIO_DEBOUNCE_EN
  localparam int EXTRA = 8;
`else
  localparam int EXTRA = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [37:0] io_in, io_out, io_oeb;
  logic [2:0]  user_irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd;
  logic        acked;

  always #5 clk = ~clk;

  wb_gpio_irq #(
    .ADDR_BASE   (BASE),
    .N_IO        (38),
    .N_IRQ       (3),
    .SYNC_STAGES (2),
    .DEB_CYCLES  (8)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .io_in     (io_in),
    .io_out    (io_out),
    .io_oeb    (io_oeb),
    .user_irq  (user_irq)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Starts at 1 time unit after a rising edge and returns at the same phase after the ack edge.
  task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rdat, output logic ack_seen);
    wbs_adr_i = adr;
    wbs_we_i  = we;
    wbs_dat_i = dat;
    wbs_sel_i = sel;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    ack_seen  = 1'b0;
    rdat      = '0;
    for (int i = 0; i < 16 && !ack_seen; i++) begin
      tick(1);
      if (wbs_ack_o === 1'b1) begin
        ack_seen = 1'b1;
        rdat     = wbs_dat_o;
      end
    end
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
  endtask

  task automatic wb_read(input string tag, input logic [7:0] off, output logic [31:0] rdat);
    logic a;
    wb_xfer(BASE + 32'(off), 1'b0, '0, 4'hF, rdat, a);
    check({tag, " ack"}, 64'(a), 64'd1);
  endtask

  task automatic wb_write(input string tag, input logic [7:0] off, input logic [31:0] dat,
                          input logic [3:0] sel);
    logic [31:0] d;
    logic        a;
    wb_xfer(BASE + 32'(off), 1'b1, dat, sel, d, a);
    check({tag, " ack"}, 64'(a), 64'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    wbs_sel_i = '0;
    wbs_adr_i = '0;
    wbs_dat_i = '0;
    io_in     = '0;
    tick(3);
    rst_n = 1'b1;

    check("rst io_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);
    check("rst io_out", 64'(io_out), 64'h0);
    check("rst user_irq", 64'(user_irq), 64'h0);
    check("rst ack", 64'(wbs_ack_o), 64'h0);
    check("rst dat", 64'(wbs_dat_o), 64'h0);

    wb_read("id", 8'h30, rd);
    check("id value", 64'(rd), 64'h4703_2602);
    tick(1);

    // Byte-masked write held for an extra cycle: single ack, low half only.
    wbs_adr_i = BASE;
    wbs_we_i  = 1'b1;
    wbs_dat_i = 32'hDEAD_BEEF;
    wbs_sel_i = 4'b0011;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    tick(1);
    check("wr0 ack", 64'(wbs_ack_o), 64'h1);
    check("wr0 io_out", 64'(io_out), 64'hBEEF);
    tick(1);
    check("wr0 ack one cycle", 64'(wbs_ack_o), 64'h0);
    check("dat zero outside ack", 64'(wbs_dat_o), 64'h0);
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;

    wb_read("out_lo", 8'h00, rd);
    check("out_lo value", 64'(rd), 64'h0000_BEEF);
    wb_write("out_hi", 8'h04, 32'hFFFF_FFFF, 4'hF);
    check("out_hi io_out", 64'(io_out), 64'h3F_0000_BEEF);
    wb_read("out_hi rd", 8'h04, rd);
    check("out_hi masked", 64'(rd), 64'h0000_003F);
    wb_write("oeb_lo", 8'h08, 32'h0, 4'hF);
    check("oeb io_oeb", 64'(io_oeb), 64'h3F_0000_0000);

    wb_xfer(BASE + 32'h100, 1'b0, '0, 4'hF, rd, acked);
    check("outside window no ack", 64'(acked), 64'h0);
    wb_xfer(BASE + 32'h3C, 1'b0, '0, 4'hF, rd, acked);
    check("unmapped ack", 64'(acked), 64'h1);
    check("unmapped data", 64'(rd), 64'h0);

    // Rising edge on pin 5 -> STAT at k+3, user_irq[2] at k+4 (k = first sampling edge).
    wb_write("ie_lo", 8'h18, 32'h20, 4'hF);
    wb_write("pol_lo", 8'h20, 32'h20, 4'hF);
    io_in[5] = 1'b1;
    tick(3 + EXTRA);
    wb_read("stat early", 8'h28, rd);
    check("stat not yet set", 64'(rd), 64'h0);
    check("irq not yet", 64'(user_irq), 64'h0);
    tick(1);
    check("irq rises", 64'(user_irq), 64'h4);
    wb_read("stat", 8'h28, rd);
    check("stat bit5", 64'(rd), 64'h20);
    wb_read("in_lo", 8'h10, rd);
    check("in_lo bit5", 64'(rd), 64'h20);

    wb_write("w1c", 8'h28, 32'h20, 4'hF);
    check("irq at w1c edge", 64'(user_irq), 64'h4);
    tick(1);
    check("irq cleared", 64'(user_irq), 64'h0);
    wb_read("stat clr", 8'h28, rd);
    check("stat cleared", 64'(rd), 64'h0);

    // Re-arm bit 5, then W1C exactly on the edge that sets it again.
    io_in[5] = 1'b0;
    tick(6 + EXTRA);
    io_in[5] = 1'b1;
    tick(8 + EXTRA);
    check("irq rearmed", 64'(user_irq), 64'h4);
    io_in[5] = 1'b0;
    tick(6 + EXTRA);
    io_in[5] = 1'b1;
    tick(3 + EXTRA);
    wb_write("w1c collide", 8'h28, 32'h20, 4'hF);
    check("collide irq t", 64'(user_irq), 64'h4);
    tick(1);
    check("collide irq t+1", 64'(user_irq), 64'h4);
    wb_read("stat collide", 8'h28, rd);
    check("stat set wins", 64'(rd), 64'h20);

    // Pin 9: falling polarity, IE clear; status still latches, no irq.
    io_in[9] = 1'b1;
    tick(6 + EXTRA);
    wb_read("stat rise9", 8'h28, rd);
    check("pin9 rise ignored", 64'(rd), 64'h20);
    io_in[9] = 1'b0;
    tick(6 + EXTRA);
    wb_read("stat fall9", 8'h28, rd);
    check("pin9 fall latched", 64'(rd), 64'h220);
    check("pin9 no irq", 64'(user_irq), 64'h4);

    // Reset asserted while a read is pending: no ack, registers back to reset.
    wbs_adr_i = BASE + 32'h30;
    wbs_we_i  = 1'b0;
    wbs_sel_i = 4'hF;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    #2;
    rst_n = 1'b0;
    tick(1);
    check("midrst ack", 64'(wbs_ack_o), 64'h0);
    check("midrst io_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);
    check("midrst io_out", 64'(io_out), 64'h0);
    check("midrst irq", 64'(user_irq), 64'h0);
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    io_in     = '0;
    rst_n     = 1'b1;
    tick(1);
    wb_read("id retry", 8'h30, rd);
    check("id retry value", 64'(rd), 64'h4703_2602);

`ifdef WB_GPIO_DEBOUNCE_EN
    tick(20);
    io_in[0] = 1'b1;
    tick(5);
    io_in[0] = 1'b0;
    tick(30);
    wb_read("deb glitch", 8'h10, rd);
    check("deb glitch filtered", 64'(rd[0]), 64'h0);
    io_in[0] = 1'b1;
    tick(16);
    wb_read("deb pulse", 8'h10, rd);
    check("deb pulse passes", 64'(rd[0]), 64'h1);
    tick(2);
    io_in[0] = 1'b0;
`endif

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
